// File: rtl/matrix_scanner.sv
// matrix_scanner
//   Walks the matrix-storage metadata table one slot per cycle and reports
//   every occupied slot whose dimensions match the requested m x n. A zero
//   target dimension is a wildcard. The results are a per-slot match mask, a
//   match count and a stream of matching IDs in ascending order.
//
//   Optional feature, enabled by defining MATRIX_SCANNER_LIMIT_EN:
//   the scan stops early once MAX_MATCHES matches have been found.
//
// Ports
//   clk, rst              clock; synchronous active-high reset
//   start                 one-cycle scan request (honoured only in IDLE)
//   target_m, target_n    requested dimensions, 0 = any
//   busy, done            scan in progress / one-cycle completion pulse
//   meta_rd_en/addr       metadata read port (data returns one cycle later)
//   meta_occupied/m/n     metadata read data
//   match_valid/id        one pulse per matching slot
//   match_mask/count      accumulated results, held until the next start
module matrix_scanner #(
    parameter int unsigned MAX_SLOTS   = 8,
    parameter int unsigned DIM_W       = 3,
    parameter int unsigned SLOT_W      = $clog2(MAX_SLOTS),
    parameter int unsigned CNT_W       = $clog2(MAX_SLOTS + 1),
    parameter int unsigned MAX_MATCHES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DIM_W-1:0]     target_m,
    input  logic [DIM_W-1:0]     target_n,
    output logic                 busy,
    output logic                 done,
    output logic                 meta_rd_en,
    output logic [SLOT_W-1:0]    meta_rd_addr,
    input  logic                 meta_occupied,
    input  logic [DIM_W-1:0]     meta_m,
    input  logic [DIM_W-1:0]     meta_n,
    output logic                 match_valid,
    output logic [SLOT_W-1:0]    match_id,
    output logic [MAX_SLOTS-1:0] match_mask,
    output logic [CNT_W-1:0]     match_count
);

`ifdef MATRIX_SCANNER_LIMIT_EN
    localparam bit LimitEn = 1'b1;
`else
    localparam bit LimitEn = 1'b0;
`endif

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StScan  = 2'd1;
    localparam logic [1:0] StFlush = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    localparam logic [SLOT_W-1:0] LastIdx  = SLOT_W'(MAX_SLOTS - 1);
    localparam logic [CNT_W-1:0]  LimitCnt = CNT_W'(MAX_MATCHES);

    logic [1:0]           state_q, state_d;
    logic [SLOT_W-1:0]    idx_q, idx_d;
    logic [DIM_W-1:0]     tgt_m_q, tgt_m_d;
    logic [DIM_W-1:0]     tgt_n_q, tgt_n_d;
    // A read was issued last cycle; its data is on meta_* this cycle.
    logic                 pend_q, pend_d;
    logic [SLOT_W-1:0]    pend_slot_q, pend_slot_d;
    logic [MAX_SLOTS-1:0] mask_q, mask_d;
    logic [CNT_W-1:0]     count_q, count_d;

    logic eval_en;
    logic hit;
    logic limit_hit;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        tgt_m_d     = tgt_m_q;
        tgt_n_d     = tgt_n_q;
        mask_d      = mask_q;
        count_d     = count_q;

        busy         = (state_q == StScan) || (state_q == StFlush);
        done         = (state_q == StDone);
        meta_rd_en   = (state_q == StScan);
        meta_rd_addr = (state_q == StScan) ? idx_q : '0;

        pend_d      = meta_rd_en;
        pend_slot_d = idx_q;

        // Once the limit is reached, the read still in flight is dropped.
        eval_en = pend_q && !(LimitEn && (count_q >= LimitCnt));
        hit     = eval_en && meta_occupied
                  && ((tgt_m_q == '0) || (meta_m == tgt_m_q))
                  && ((tgt_n_q == '0) || (meta_n == tgt_n_q));

        match_valid = hit;
        match_id    = hit ? pend_slot_q : '0;

        if (hit) begin
            mask_d[pend_slot_q] = 1'b1;
            count_d             = count_q + CNT_W'(1);
        end

        limit_hit = LimitEn && hit && (count_d == LimitCnt);

        case (state_q)
            StIdle: begin
                if (start) begin
                    tgt_m_d = target_m;
                    tgt_n_d = target_n;
                    mask_d  = '0;
                    count_d = '0;
                    idx_d   = '0;
                    state_d = StScan;
                end
            end
            StScan: begin
                idx_d = idx_q + SLOT_W'(1);
                if (limit_hit || (idx_q == LastIdx)) begin
                    state_d = StFlush;
                end
            end
            StFlush: begin
                state_d = StDone;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            tgt_m_q     <= '0;
            tgt_n_q     <= '0;
            pend_q      <= 1'b0;
            pend_slot_q <= '0;
            mask_q      <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            tgt_m_q     <= tgt_m_d;
            tgt_n_q     <= tgt_n_d;
            pend_q      <= pend_d;
            pend_slot_q <= pend_slot_d;
            mask_q      <= mask_d;
            count_q     <= count_d;
        end
    end

    assign match_mask  = mask_q;
    assign match_count = count_q;

endmodule

// File: tb/tb_matrix_scanner.sv
module tb_matrix_scanner;

    localparam int MS = 8;
    localparam int MM = 2;

`ifdef MATRIX_SCANNER_LIMIT_EN
    localparam bit LIMIT = 1'b1;
`else
    localparam bit LIMIT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] target_m, target_n;
    logic       busy, done, meta_rd_en;
    logic [2:0] meta_rd_addr;
    logic       meta_occupied;
    logic [2:0] meta_m, meta_n;
    logic       match_valid;
    logic [2:0] match_id;
    logic [7:0] match_mask;
    logic [3:0] match_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Storage contents seen by the scanner.
    bit         occ [MS];
    logic [2:0] mm  [MS];
    logic [2:0] nn  [MS];

    matrix_scanner #(
        .MAX_SLOTS  (MS),
        .DIM_W      (3),
        .MAX_MATCHES(MM)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .target_m     (target_m),
        .target_n     (target_n),
        .busy         (busy),
        .done         (done),
        .meta_rd_en   (meta_rd_en),
        .meta_rd_addr (meta_rd_addr),
        .meta_occupied(meta_occupied),
        .meta_m       (meta_m),
        .meta_n       (meta_n),
        .match_valid  (match_valid),
        .match_id     (match_id),
        .match_mask   (match_mask),
        .match_count  (match_count)
    );

    always #5 clk = ~clk;

    // Metadata memory: one-cycle read latency, junk when no read was issued.
    always @(posedge clk) begin
        if (meta_rd_en) begin
            meta_occupied <= occ[meta_rd_addr];
            meta_m        <= mm[meta_rd_addr];
            meta_n        <= nn[meta_rd_addr];
        end else begin
            meta_occupied <= 1'($urandom);
            meta_m        <= 3'($urandom);
            meta_n        <= 3'($urandom);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_busy"}, 32'(busy), 0);
        check_eq({tag, "_done"}, 32'(done), 0);
        check_eq({tag, "_rd_en"}, 32'(meta_rd_en), 0);
        check_eq({tag, "_rd_addr"}, 32'(meta_rd_addr), 0);
        check_eq({tag, "_valid"}, 32'(match_valid), 0);
        check_eq({tag, "_id"}, 32'(match_id), 0);
        check_eq({tag, "_mask"}, 32'(match_mask), 0);
        check_eq({tag, "_count"}, 32'(match_count), 0);
    endtask

    task automatic plan_table();
        for (int i = 0; i < MS; i++) begin
            occ[i] = 1'b0;
            mm[i]  = 3'($urandom);
            nn[i]  = 3'($urandom);
        end
        occ[0] = 1'b1; mm[0] = 3'd2; nn[0] = 3'd3;
        occ[3] = 1'b1; mm[3] = 3'd2; nn[3] = 3'd3;
        occ[5] = 1'b1; mm[5] = 3'd3; nn[5] = 3'd2;
    endtask

    // One full scan, checked against a list-based model of the table.
    task automatic run_scan(input logic [2:0] tm, input logic [2:0] tn,
                            input bit poke_busy, input bit poke_done);
        int exp_ids[$];
        int got_ids[$];
        logic [7:0] exp_mask = '0;
        int limit = LIMIT ? MM : MS;
        int exp_done = MS + 2;
        int exp_reads = MS;
        int n_reads = 0, n_busy = 0, n_done = 0, done_cyc = -1, last_rd = -1;

        for (int i = 0; i < MS; i++) begin
            if (exp_ids.size() < limit && occ[i]
                && (tm == 0 || mm[i] == tm) && (tn == 0 || nn[i] == tn)) begin
                exp_ids.push_back(i);
                exp_mask[i] = 1'b1;
            end
        end
        if (LIMIT && exp_ids.size() == MM) begin
            int s = exp_ids[$];
            exp_done  = (s + 4 < MS + 2) ? s + 4 : MS + 2;
            exp_reads = (s + 2 < MS) ? s + 2 : MS;
        end

        @(negedge clk);
        target_m = tm; target_n = tn; start = 1'b1;
        @(negedge clk);
        target_m = 3'($urandom); target_n = 3'($urandom);
        for (int cyc = 1; cyc <= MS + 5; cyc++) begin
            start = 1'b0;
            if (match_valid) begin
                got_ids.push_back(int'(match_id));
                check_eq("match_cycle", cyc, 32'(match_id) + 2);
            end
            if (meta_rd_en) begin
                check_eq("rd_addr", 32'(meta_rd_addr), n_reads);
                n_reads++;
                last_rd = cyc;
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (busy) n_busy++;
            if (poke_busy && cyc == 3) start = 1'b1;
            if (poke_done && cyc == exp_done) start = 1'b1;
            @(negedge clk);
        end
        start = 1'b0;

        check_eq("done_pulses", n_done, 1);
        check_eq("done_cycle", done_cyc, exp_done);
        check_eq("busy_cycles", n_busy, exp_done - 1);
        check_eq("reads", n_reads, exp_reads);
        check_eq("last_read_cycle", last_rd, exp_reads);
        check_eq("match_num", got_ids.size(), exp_ids.size());
        for (int i = 0; i < exp_ids.size(); i++) begin
            check_eq("match_id", (i < got_ids.size()) ? got_ids[i] : -1, exp_ids[i]);
        end
        check_eq("mask", 32'(match_mask), 32'(exp_mask));
        check_eq("count", 32'(match_count), exp_ids.size());
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; target_m = '0; target_n = '0;
        for (int i = 0; i < MS; i++) begin
            occ[i] = 1'b0; mm[i] = '0; nn[i] = '0;
        end
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;

        // Directed table scans.
        plan_table();
        run_scan(3'd2, 3'd3, 1'b0, 1'b0);
        run_scan(3'd0, 3'd2, 1'b0, 1'b0);
        run_scan(3'd0, 3'd0, 1'b1, 1'b1);
        for (int i = 0; i < MS; i++) begin
            occ[i] = 1'b0; mm[i] = 3'd1; nn[i] = 3'd1;
        end
        run_scan(3'd1, 3'd1, 1'b0, 1'b0);
        for (int i = 0; i < MS; i++) begin
            occ[i] = 1'b1; mm[i] = 3'd2; nn[i] = 3'd2;
        end
        run_scan(3'd2, 3'd2, 1'b0, 1'b0);

        // Reset during a scan: no done afterwards, outputs cleared.
        plan_table();
        @(negedge clk);
        target_m = 3'd0; target_n = 3'd0; start = 1'b1;
        @(negedge clk);                // cycle 1
        start = 1'b0;
        repeat (2) @(negedge clk);     // cycle 3
        target_m = 3'd1; target_n = 3'd1; start = 1'b1;
        @(negedge clk);                // cycle 4
        start = 1'b0;
        @(negedge clk);                // cycle 5
        rst = 1'b1;
        @(negedge clk);                // cycle 6
        rst = 1'b0;
        check_idle_outputs("abort");
        begin
            int n_act = 0;
            for (int c = 0; c < 12; c++) begin
                if (done || busy || meta_rd_en || match_valid) n_act++;
                @(negedge clk);
            end
            check_eq("abort_quiet", n_act, 0);
        end
        run_scan(3'd2, 3'd3, 1'b0, 1'b0);

        // Randomized tables and targets.
        for (int t = 0; t < 30; t++) begin
            for (int i = 0; i < MS; i++) begin
                occ[i] = 1'($urandom_range(0, 1));
                mm[i]  = 3'($urandom_range(1, 3));
                nn[i]  = 3'($urandom_range(1, 3));
            end
            run_scan(3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/matrix_scanner.md
Name: matrix_scanner

Overview:
- Upstream helper of the operand-selection FSM. Entered from its SCAN_MATRICES state, which then waits in WAIT_SCANNER.
- Walks the matrix-storage metadata table slot by slot and finds every occupied slot whose dimensions match the requested m x n.
- Produces three results: a per-slot match mask, a match count and a streamed list of matching IDs. The selector uses these to build its displayed list and to validate the chosen IDs.

Parameters:
- MAX_SLOTS, 8, number of metadata slots in storage; IDs are 0..MAX_SLOTS-1.
- DIM_W, 3, width of a dimension field; value 0 is a wildcard.
- SLOT_W, $clog2(MAX_SLOTS), width of slot address and ID.
- CNT_W, $clog2(MAX_SLOTS+1), width of the match count.
- MAX_MATCHES, 4, match limit; used only with the optional feature.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle scan request; sampled only in IDLE.
- target_m  in  DIM_W  requested rows; 0 = any.
- target_n  in  DIM_W  requested columns; 0 = any.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the scan completes.
- meta_rd_en  out  1  metadata read strobe.
- meta_rd_addr  out  SLOT_W  slot being read.
- meta_occupied  in  1  slot holds a matrix; valid 1 cycle after meta_rd_en.
- meta_m  in  DIM_W  stored rows; same timing as meta_occupied.
- meta_n  in  DIM_W  stored columns; same timing as meta_occupied.
- match_valid  out  1  one-cycle pulse per matching slot.
- match_id  out  SLOT_W  ID of the matching slot; valid with match_valid.
- match_mask  out  MAX_SLOTS  bit i set when slot i matched.
- match_count  out  CNT_W  number of matches found.

Behaviour:
- Reset: state IDLE; all outputs 0 (busy, done, meta_rd_en, meta_rd_addr, match_valid, match_id, match_mask, match_count). Reset has priority over every other event, including mid-scan. No done pulse is produced for an aborted scan.
- States:
  - IDLE: on start, latch target_m and target_n, clear match_mask and match_count, go to SCAN. Targets sampled at any other time have no effect.
  - SCAN: meta_rd_en=1 and meta_rd_addr=idx every cycle for idx = 0..MAX_SLOTS-1, one slot per cycle. After issuing MAX_SLOTS-1, go to FLUSH.
  - FLUSH: meta_rd_en=0; evaluate the last slot, then go to DONE.
  - DONE: done=1 for one cycle, busy=0, return to IDLE.
- Compare pipeline: the slot read in cycle k is evaluated in cycle k+1.
  - Match condition: meta_occupied && (target_m==0 || meta_m==target_m) && (target_n==0 || meta_n==target_n).
  - On a match, in the evaluation cycle: match_valid=1, match_id=slot, set match_mask[slot], increment match_count.
- Cycle numbering, with start accepted at cycle 0:
  - reads in cycles 1..MAX_SLOTS;
  - match pulses in cycles 2..MAX_SLOTS+1;
  - done at cycle MAX_SLOTS+2 (10 for the default).
  - busy is high in cycles 1..MAX_SLOTS+1.
- Matches stream in ascending ID order, at most one per cycle.
- match_mask and match_count hold their final values after done until the next accepted start.
- match_count never exceeds MAX_SLOTS, so no overflow is possible.
- start while busy is ignored, with no restart.
- start in the same cycle as done is ignored; the block is in DONE, not IDLE.
- Zero matches: done still pulses, count 0, mask 0, no match_valid.
- meta_* inputs are ignored in any cycle not following a meta_rd_en.

Optional Feature:
- Macro: MATRIX_SCANNER_LIMIT_EN.
- Defined:
  - When match_count reaches MAX_MATCHES in an evaluation cycle, SCAN stops issuing reads from the next cycle and the block goes to FLUSH, then DONE.
  - A read already in flight is discarded, not counted.
  - done follows within 2 cycles of the limiting match.
  - match_count saturates at MAX_MATCHES.
- Undefined: the scan always covers all MAX_SLOTS and MAX_MATCHES is unused.

Test Plan:
- Occupied slots 0 (2x3), 3 (2x3), 5 (3x2); others empty; start with target 2x3 -> match_valid pulses IDs 0 then 3; mask=8'b0000_1001; count=2; done at cycle 10.
- Same table, target 0x2 -> only slot 5 matches; mask=8'b0010_0000; count=1.
- Same table, target 0x0 -> IDs 0,3,5 stream; count=3; empty slots with stale m/n never match.
- All slots empty, target 1x1 -> no match_valid; count=0; mask=0; done still at cycle 10.
- Pulse start at cycle 3 mid-scan, then assert rst at cycle 5 -> second start ignored; after reset all outputs 0, state IDLE, no done; new start gives a clean scan.
- MATRIX_SCANNER_LIMIT_EN, MAX_MATCHES=2, all 8 slots 2x2, target 2x2 -> IDs 0,1 only; count=2; meta_rd_en low after the read of slot 2; done by cycle 6.
